// File: rtl/audio_scheduler.sv
// audio_scheduler: background music arbiter with preemptive sound effects.
// Every effect is framed by muted gaps so the generators re-arm cleanly.
module audio_scheduler #(
   parameter int FX_LEN  = 25000000,
   parameter int GAP_LEN = 1000,
   parameter int CNT_W   = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] mode,
   input  logic [2:0] req,
   input  logic       audio_start,
   input  logic       audio_game,
   input  logic [2:0] audio_fx,
   output logic       en_start,
   output logic       en_game,
   output logic [2:0] en_fx,
   output logic [1:0] fx_id,
   output logic       busy,
   output logic       audio
);

   localparam logic [1:0] S_BG   = 2'd0;
   localparam logic [1:0] S_GIN  = 2'd1;
   localparam logic [1:0] S_FX   = 2'd2;
   localparam logic [1:0] S_GOUT = 2'd3;

   localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] FX_LD  = CNT_W'(FX_LEN - 1);

   logic [1:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       pending, pending_n, grant;
   logic [1:0]       fx_q, fx_n, top;
   logic [1:0]       mode_q, mode_n;
   logic             audio_q, audio_n;
   logic             cnt_zero, any_pend;

   function automatic logic [2:0] onehot(input logic [1:0] id);
      return {id == 2'd3, id == 2'd2, id == 2'd1};
   endfunction

   assign cnt_zero = (cnt == '0);
   assign any_pend = |pending;

   // effect ids double as priority: kill=3 > hit=2 > shoot=1
   always_comb begin
      top = 2'd0;
      priority case (1'b1)
         pending[2]: top = 2'd3;
         pending[1]: top = 2'd2;
         pending[0]: top = 2'd1;
         default:    top = 2'd0;
      endcase
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fx_n    = fx_q;
      grant   = 3'b000;
      unique case (state)
         S_BG: begin
            if (any_pend) begin
               state_n = S_GIN;
               cnt_n   = GAP_LD;
            end
         end
         S_GIN: begin
            if (!cnt_zero) begin
               cnt_n = cnt - CNT_W'(1);
            end else if (top != 2'd0) begin
               state_n = S_FX;
               fx_n    = top;
               grant   = onehot(top);
               cnt_n   = FX_LD;
            end else begin
               state_n = S_GOUT;
               cnt_n   = GAP_LD;
            end
         end
         S_FX: begin
            if (top > fx_q) begin
               state_n = S_GIN;
               cnt_n   = GAP_LD;
               fx_n    = 2'd0;
            end else if (cnt_zero) begin
               state_n = any_pend ? S_GIN : S_GOUT;
               cnt_n   = GAP_LD;
               fx_n    = 2'd0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_GOUT: begin
            if (!cnt_zero) begin
               cnt_n = cnt - CNT_W'(1);
            end else if (any_pend) begin
               state_n = S_GIN;
               cnt_n   = GAP_LD;
            end else begin
               state_n = S_BG;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = S_BG;
            cnt_n   = '0;
            fx_n    = 2'd0;
         end
      endcase
   end

   // a request for the source being granted this cycle is absorbed
   assign pending_n = (pending | req) & ~grant;
   assign mode_n    = (state == S_BG) ? mode : mode_q;

   always_comb begin
      audio_n = 1'b0;
      if (state_n == S_FX) begin
         audio_n = |(audio_fx & onehot(fx_n));
      end else if (state_n == S_BG) begin
         audio_n = ((mode_n == 2'b01) & audio_start) |
                   ((mode_n == 2'b10) & audio_game);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_BG;
         cnt     <= '0;
         pending <= 3'b000;
         fx_q    <= 2'd0;
         mode_q  <= 2'b00;
         audio_q <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         pending <= pending_n;
         fx_q    <= fx_n;
         mode_q  <= mode_n;
         audio_q <= audio_n;
      end
   end

   assign en_start = (state == S_BG) && (mode_q == 2'b01);
   assign en_game  = (state == S_BG) && (mode_q == 2'b10);
   assign en_fx    = onehot(fx_q);
   assign fx_id    = fx_q;
   assign busy     = (state != S_BG);
   assign audio    = audio_q;

endmodule

// File: tb/tb_audio_scheduler.sv
// tb_audio_scheduler: directed scenarios for audio_scheduler.
// Runs with FX_LEN=8, GAP_LEN=2; each cycle is coded BG/gap/effect.
module tb_audio_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] mode = 2'b10;
   logic [2:0] req = 3'b000;
   logic       audio_start = 1'b0;
   logic       audio_game = 1'b0;
   logic [2:0] audio_fx = 3'b000;
   logic       en_start, en_game, busy, audio;
   logic [2:0] en_fx;
   logic [1:0] fx_id;

   int checks = 0;
   int failures = 0;
   int exp_q[$];
   logic       p_start, p_game;
   logic [2:0] p_fx;
   logic [8:0] got, want;

   audio_scheduler #(
      .FX_LEN(8), .GAP_LEN(2), .CNT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .req(req),
      .audio_start(audio_start), .audio_game(audio_game),
      .audio_fx(audio_fx), .en_start(en_start),
      .en_game(en_game), .en_fx(en_fx), .fx_id(fx_id),
      .busy(busy), .audio(audio)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_src();
      audio_start = 1'($urandom);
      audio_game  = 1'($urandom);
      audio_fx    = 3'($urandom);
      p_start = audio_start;
      p_game  = audio_game;
      p_fx    = audio_fx;
   endtask

   task automatic add(input int code, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(code);
   endtask

   // code: 0 muted gap, 1..3 effect id playing, 4 BG with game music
   function automatic logic [8:0] model(input int code);
      logic [2:0] oh;
      logic [1:0] id;
      logic       a;
      oh = 3'b000;
      id = 2'd0;
      if (code >= 1 && code <= 3) begin
         oh = 3'(1 << (code - 1));
         id = 2'(code);
      end
      a = (code == 4) ? p_game : |(oh & p_fx);
      return {code != 4, id, oh, code == 4, 1'b0, a};
   endfunction

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      got = {busy, fx_id, en_fx, en_game, en_start, audio};
      checks++;
      if (got !== 9'd0) begin
         failures++;
         $display("FAIL reset_async got=%b exp=%b", got, 9'd0);
      end
      step();
      step();
      got = {busy, fx_id, en_fx, en_game, en_start, audio};
      checks++;
      if (got !== 9'd0) begin
         failures++;
         $display("FAIL reset_held got=%b exp=%b", got, 9'd0);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_background();
      logic [1:0] ml [5];
      ml = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b10};
      for (int m = 0; m < 5; m++) begin
         mode = ml[m];
         for (int c = 0; c < 3; c++) begin
            drive_src();
            step();
            want = {1'b0, 2'd0, 3'b000, mode == 2'b10,
                    mode == 2'b01,
                    (mode == 2'b01) ? p_start :
                    (mode == 2'b10) ? p_game : 1'b0};
            got = {busy, fx_id, en_fx, en_game, en_start, audio};
            checks++;
            if (got !== want) begin
               failures++;
               $display("FAIL bg mode=%b c=%0d got=%b exp=%b",
                        mode, c, got, want);
            end
         end
      end
   endtask

   task automatic test_single();
      exp_q.delete();
      add(4, 1); add(0, 2); add(1, 8); add(0, 2); add(4, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
         req = (i == 0) ? 3'b001 : 3'b000;
         drive_src();
         step();
         want = model(exp_q[i]);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL single cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
      req = 3'b000;
   endtask

   task automatic test_preempt();
      exp_q.delete();
      add(4, 1); add(0, 2); add(1, 4); add(0, 2);
      add(3, 8); add(0, 2); add(4, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         req = (i == 0) ? 3'b001 : (i == 6) ? 3'b100 : 3'b000;
         drive_src();
         step();
         want = model(exp_q[i]);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL preempt cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
      req = 3'b000;
   endtask

   task automatic test_requeue();
      exp_q.delete();
      add(4, 1); add(0, 2); add(3, 8); add(0, 2); add(3, 8);
      add(0, 2); add(1, 8); add(0, 2); add(4, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
         req = (i == 0) ? 3'b100 : (i == 4) ? 3'b100 :
               (i == 5) ? 3'b001 : 3'b000;
         drive_src();
         step();
         want = model(exp_q[i]);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL requeue cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
      req = 3'b000;
   endtask

   task automatic test_reset_mid();
      exp_q.delete();
      add(4, 1); add(0, 2); add(1, 4);
      for (int i = 0; i < exp_q.size(); i++) begin
         req = (i == 0) ? 3'b001 : 3'b000;
         drive_src();
         step();
         want = model(exp_q[i]);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
      req = 3'b000;
      #2 rst_n = 1'b0;
      #1;
      got = {busy, fx_id, en_fx, en_game, en_start, audio};
      checks++;
      if (got !== 9'd0) begin
         failures++;
         $display("FAIL rstmid_async got=%b exp=%b", got, 9'd0);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive_src();
         step();
         want = model(4);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL rstmid_post cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_q.delete();
      add(4, 1); add(0, 2); add(3, 8); add(0, 2); add(2, 8);
      add(0, 2); add(1, 8); add(0, 2); add(4, 3);
      for (int i = 0; i < exp_q.size(); i++) begin
         req = (i == 0) ? 3'b111 : 3'b000;
         drive_src();
         step();
         want = model(exp_q[i]);
         got = {busy, fx_id, en_fx, en_game, en_start, audio};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL b2b cyc=%0d got=%b exp=%b",
                     i, got, want);
         end
      end
      req = 3'b000;
   endtask

   initial begin
      test_reset();
      test_background();
      test_single();
      test_preempt();
      test_requeue();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
